// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD adder.
//   state_t     : controller states (IDLE / RUN / DONE)
//   DIG_W       : width of one BCD digit
//   DIG_MAX     : largest legal BCD digit value
//   BCD_CORR    : correction added when a digit sum leaves the decimal range
//   dig_res_t   : single-digit add result (carry + digit)
//   bcd_digit_add / bcd_digit_bad : per-digit helpers used by the pair adder
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DIG_W = 4;
  localparam logic [DIG_W-1:0] DIG_MAX  = 4'd9;
  localparam logic [DIG_W-1:0] BCD_CORR = 4'd6;

  typedef struct packed {
    logic             carry;
    logic [DIG_W-1:0] digit;
  } dig_res_t;

  // Decimal add of one digit pair plus carry. Defined for every 4-bit input,
  // including non-BCD codes: the raw sum (max 31) is corrected by +6 whenever
  // it exceeds 9 and the low nibble is kept.
  function automatic dig_res_t bcd_digit_add(input logic [DIG_W-1:0] a,
                                             input logic [DIG_W-1:0] b,
                                             input logic             c);
    logic [DIG_W+1:0] s;
    dig_res_t         r;
    s = {2'b00, a} + {2'b00, b} + {{(DIG_W+1){1'b0}}, c};
    if (s > {2'b00, DIG_MAX}) begin
      s       = s + {2'b00, BCD_CORR};
      r.carry = 1'b1;
    end else begin
      r.carry = 1'b0;
    end
    r.digit = s[DIG_W-1:0];
    return r;
  endfunction

  function automatic logic bcd_digit_bad(input logic [DIG_W-1:0] d);
    return (d > DIG_MAX);
  endfunction

endpackage

// File: rtl/bcd_pair_add.sv
// Combinational two-digit BCD adder slice.
//   a, b     : 2-digit packed BCD operands (digit 0 in [3:0])
//   cin      : carry into the low digit
//   sum_lo   : low result digit
//   sum_hi   : high result digit
//   cout     : decimal carry out of the high digit
//   bad      : any of the four operand digits is above 9
module bcd_pair_add
  import bcd_pkg::*;
(
  input  logic [2*DIG_W-1:0] a,
  input  logic [2*DIG_W-1:0] b,
  input  logic               cin,
  output logic [DIG_W-1:0]   sum_lo,
  output logic [DIG_W-1:0]   sum_hi,
  output logic               cout,
  output logic               bad
);

  dig_res_t lo, hi;

  always_comb begin
    lo     = bcd_digit_add(a[DIG_W-1:0], b[DIG_W-1:0], cin);
    hi     = bcd_digit_add(a[2*DIG_W-1:DIG_W], b[2*DIG_W-1:DIG_W], lo.carry);
    sum_lo = lo.digit;
    sum_hi = hi.digit;
    cout   = hi.carry;
    bad    = bcd_digit_bad(a[DIG_W-1:0])       | bcd_digit_bad(b[DIG_W-1:0]) |
             bcd_digit_bad(a[2*DIG_W-1:DIG_W]) | bcd_digit_bad(b[2*DIG_W-1:DIG_W]);
  end

endmodule

// File: rtl/bcd_add_seq.sv
// Sequential packed-BCD adder: one digit pair per clock.
//   clk_in   : clock, rising edge
//   rst_in   : synchronous active-high reset
//   start_in : start request, honoured only in IDLE
//   a_in     : operand A, NDIG packed BCD digits
//   b_in     : operand B, NDIG packed BCD digits
//   cin_in   : carry into digit 0
//   sum_out  : packed BCD result, held from DONE until the next start
//   cout_out : decimal carry out of the top digit
//   busy_out : operation in progress (RUN or DONE)
//   done_out : one-cycle result-valid pulse
//   err_out  : a processed operand digit was above 9
// NDIG must be even and at least 2.
// A start accepted at edge 0 runs pairs 0..NDIG/2-1 on edges 1..NDIG/2 and
// sits in DONE for one cycle; done_out is sampled high on edge NDIG/2+1.
module bcd_add_seq
  import bcd_pkg::*;
#(
  parameter int NDIG = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [DIG_W*NDIG-1:0] a_in,
  input  logic [DIG_W*NDIG-1:0] b_in,
  input  logic                  cin_in,
  output logic [DIG_W*NDIG-1:0] sum_out,
  output logic                  cout_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  err_out
);

  localparam int W     = DIG_W * NDIG;
  localparam int PAIR_W = 2 * DIG_W;
  localparam int NPAIR = NDIG / 2;
  localparam int PW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;

  state_t            state_q, state_d;
  logic [W-1:0]      a_q, b_q, sum_q;
  logic              cin_q, carry_q, cout_q, err_q;
  logic [PW-1:0]     pair_idx;
  logic              last_pair;

  logic [PAIR_W-1:0] pair_a, pair_b;
  logic              pair_cin;
  logic [DIG_W-1:0]  pair_lo, pair_hi;
  logic              pair_cout, pair_bad;

  assign last_pair = (pair_idx == PW'(NPAIR - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_in)  state_d = ST_RUN;
      ST_RUN:  if (last_pair) state_d = ST_DONE;
      ST_DONE:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Pure decode of the state register, so start_in never reaches an output
  // combinationally.
  always_comb begin
    busy_out = (state_q != ST_IDLE);
    done_out = (state_q == ST_DONE);
  end

  // ---------------- Operand pair select ----------------
  // Mux the current digit pair out of the latched operands by pair index.
  always_comb begin
    pair_a = '0;
    pair_b = '0;
    for (int k = 0; k < NPAIR; k++) begin
      if (pair_idx == PW'(k)) begin
        pair_a = a_q[PAIR_W*k +: PAIR_W];
        pair_b = b_q[PAIR_W*k +: PAIR_W];
      end
    end
  end

  // Pair 0 takes the latched external carry; later pairs chain the
  // registered carry from the previous pair.
  assign pair_cin = (pair_idx == '0) ? cin_q : carry_q;

  bcd_pair_add u_pair (
    .a      (pair_a),
    .b      (pair_b),
    .cin    (pair_cin),
    .sum_lo (pair_lo),
    .sum_hi (pair_hi),
    .cout   (pair_cout),
    .bad    (pair_bad)
  );

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      err_q    <= 1'b0;
      pair_idx <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            a_q      <= a_in;
            b_q      <= b_in;
            cin_q    <= cin_in;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
            pair_idx <= '0;
          end
        end
        ST_RUN: begin
          for (int k = 0; k < NPAIR; k++) begin
            if (pair_idx == PW'(k))
              sum_q[PAIR_W*k +: PAIR_W] <= {pair_hi, pair_lo};
          end
          carry_q <= pair_cout;
          // Sticky: a bad digit flags the op but computation carries on.
          err_q   <= err_q | pair_bad;
          if (last_pair) begin
            cout_q   <= pair_cout;
            pair_idx <= '0;
          end else begin
            pair_idx <= pair_idx + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum_out  = sum_q;
  assign cout_out = cout_q;
  assign err_out  = err_q;

endmodule

// File: tb/tb_bcd_add_seq.sv
module tb_bcd_add_seq;
  localparam int NDIG = 8;
  localparam int W    = 4 * NDIG;
  localparam int LAT  = NDIG / 2 + 1;

  logic         clk_in = 1'b0;
  logic         rst_in, start_in, cin_in;
  logic [W-1:0] a_in, b_in, sum_out;
  logic         cout_out, busy_out, done_out, err_out;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   done_cyc[$];
  int   checks = 0, failures = 0, cyc = 0;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  bcd_add_seq #(.NDIG(NDIG)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .sum_out(sum_out), .cout_out(cout_out), .busy_out(busy_out),
    .done_out(done_out), .err_out(err_out)
  );

  task automatic chk_v(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk_in) begin
    if (done_out === 1'b1) begin
      done_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done_out=1 at cycle %0d expected no pulse", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk_v("sum", sum_out, mon_e.sum);
        chk_b("cout", cout_out, mon_e.cout);
        chk_b("err", err_out, mon_e.err);
        chk_i("latency", cyc - mon_e.acc + 1, LAT);
      end
    end
  end

  // Wait for IDLE, present operands with start, push expectation for the
  // accepting edge, then optionally keep start high / scramble the inputs.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [W-1:0] es, input logic ec, input logic ee,
                       input bit keep, input bit scramble, input bit expect_done);
    int t = 0;
    @(negedge clk_in);
    while (busy_out !== 1'b0 && t < 40) begin
      @(negedge clk_in);
      t++;
    end
    if (t >= 40) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: busy_out still %b after %0d cycles expected 0", busy_out, t);
    end
    a_in = a; b_in = b; cin_in = c; start_in = 1'b1;
    if (expect_done) exp_q.push_back('{es, ec, ee, cyc + 1});
    @(posedge clk_in); #1;
    chk_b("busy_after_start", busy_out, 1'b1);
    if (!keep) start_in = 1'b0;
    if (scramble) begin
      a_in = $urandom; b_in = $urandom; cin_in = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || busy_out !== 1'b0) && t < 200) begin
      @(negedge clk_in);
      t++;
    end
    if (t >= 200) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d results outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; start_in = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk_v("rst_sum", sum_out, '0);
    chk_b("rst_cout", cout_out, 1'b0);
    chk_b("rst_err", err_out, 1'b0);
    chk_b("rst_done", done_out, 1'b0);
    chk_b("rst_busy", busy_out, 1'b0);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Full carry ripple through all digits.
    issue(32'h99999999, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 0, 0, 1);
    // No carry anywhere.
    issue(32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0, 0, 0, 1);
    wait_idle();
    repeat (3) @(negedge clk_in);
    chk_v("hold_sum", sum_out, 32'h99999999);
    chk_b("hold_cout", cout_out, 1'b0);
    // Only the external carry.
    issue(32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0, 0, 0, 1);
    // Invalid low digit: A+0 -> 10 -> "10", flagged.
    issue(32'h0000000A, 32'h00000000, 1'b0, 32'h00000010, 1'b0, 1'b1, 0, 0, 1);
    wait_idle();
    repeat (2) @(negedge clk_in);
    chk_b("hold_err", err_out, 1'b1);
    // Valid op clears the error.
    issue(32'h00000005, 32'h00000005, 1'b0, 32'h00000010, 1'b0, 1'b0, 0, 0, 1);
    // Invalid top digit in B: F+0 -> 5 with carry out.
    issue(32'h00000000, 32'hF0000000, 1'b0, 32'h50000000, 1'b1, 1'b1, 0, 0, 1);
    // Carry out of the top pair only.
    issue(32'h50000000, 32'h50000000, 1'b0, 32'h00000000, 1'b1, 1'b0, 0, 0, 1);
    wait_idle();

    // start held high, operands scrambled during RUN: one result per 6 cycles.
    done_cyc.delete();
    issue(32'h11111111, 32'h22222222, 1'b0, 32'h33333333, 1'b0, 1'b0, 1, 1, 1);
    issue(32'h00000045, 32'h00000055, 1'b0, 32'h00000100, 1'b0, 1'b0, 1, 1, 1);
    issue(32'h99999999, 32'h99999999, 1'b1, 32'h99999999, 1'b1, 1'b0, 0, 1, 1);
    wait_idle();
    repeat (8) @(negedge clk_in);
    chk_i("cont_done_count", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      chk_i("cont_period_1", done_cyc[1] - done_cyc[0], 6);
      chk_i("cont_period_2", done_cyc[2] - done_cyc[1], 6);
    end

    // start pulsed exactly during DONE must be ignored.
    issue(32'h00000123, 32'h00000877, 1'b0, 32'h00001000, 1'b0, 1'b0, 0, 0, 1);
    begin
      int t = 0;
      while (done_out !== 1'b1 && t < 20) begin
        @(negedge clk_in);
        t++;
      end
      chk_b("done_seen", done_out, 1'b1);
    end
    a_in = 32'h00000001; b_in = 32'h00000001; cin_in = 1'b0; start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    chk_b("done_start_ignored_busy", busy_out, 1'b0);
    repeat (10) @(negedge clk_in);
    chk_v("done_start_sum_held", sum_out, 32'h00001000);

    // Reset in RUN cycle 2 aborts; nothing completes.
    issue(32'h00000011, 32'h00000011, 1'b0, '0, 1'b0, 1'b0, 0, 0, 0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    chk_v("abort_sum", sum_out, '0);
    chk_b("abort_busy", busy_out, 1'b0);
    chk_b("abort_done", done_out, 1'b0);
    chk_b("abort_cout", cout_out, 1'b0);
    chk_b("abort_err", err_out, 1'b0);
    repeat (8) @(negedge clk_in);
    issue(32'h00000011, 32'h00000011, 1'b0, 32'h00000022, 1'b0, 1'b0, 0, 0, 1);
    wait_idle();
    repeat (10) @(negedge clk_in);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
